// File: rtl/reset_seq_pkg.sv
// Shared definitions for the staged reset sequencer: FSM state encoding
// and the helper that sizes the shared cycle counter.
package reset_seq_pkg;

    typedef enum logic [1:0] {
        HOLD      = 2'd0,
        WAIT_LOCK = 2'd1,
        RELEASE   = 2'd2,
        RUN       = 2'd3
    } seq_state_t;

    // Width of a counter that must reach (largest terminal count - 1).
    // Never returns less than one bit so degenerate parameters still build.
    function automatic int cnt_width(input int a, input int b, input int c);
        int m;
        m = a;
        if (b > m) m = b;
        if (c > m) m = c;
        if (m < 2) return 1;
        return $clog2(m);
    endfunction

endpackage

// File: rtl/reset_sequencer_sync.sv
// sync_2ff: single-bit two-flop synchroniser with asynchronous active-low
// reset. Both flops clear to 0, so a synchronised signal always starts low.
module sync_2ff (
    input  logic clk,
    input  logic arst_n,
    input  logic d,
    output logic q
);

    logic meta;

    // Two-stage capture of the asynchronous input into the clk domain.
    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            meta <= 1'b0;
            q    <= 1'b0;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/reset_sequencer.sv
// reset_sequencer: waits for PLL lock, then releases NUM_STAGES per-domain
// active-low resets one at a time, STAGE_DLY cycles apart. A software
// request, or lock loss once release has begun, re-asserts every domain at
// once and restarts from a full HOLD period.
//
// Optional feature macro: RESET_SEQ_WDT_EN
//   defined   - WAIT_LOCK times out after WDT_CYCLES, sets sticky wdt_err
//               and retries through HOLD.
//   undefined - WAIT_LOCK waits indefinitely and wdt_err is tied low.
module reset_sequencer
    import reset_seq_pkg::*;
#(
    parameter int NUM_STAGES = 4,
    parameter int MIN_HOLD   = 8,
    parameter int STAGE_DLY  = 16,
    parameter int WDT_CYCLES = 1024
) (
    input  logic                  clk,
    input  logic                  arst_n,
    input  logic                  lock_in,
    input  logic                  sw_rst,
    output logic [NUM_STAGES-1:0] rst_n_out,
    output logic [NUM_STAGES-1:0] rst_out,
    output logic                  seq_done,
    output logic                  wdt_err
);

    localparam int CNT_W = cnt_width(MIN_HOLD, STAGE_DLY, WDT_CYCLES);
    localparam int IDX_W = $clog2(NUM_STAGES) + 1;

    localparam logic [CNT_W-1:0] HOLD_LAST  = CNT_W'(MIN_HOLD - 1);
    localparam logic [CNT_W-1:0] STAGE_LAST = CNT_W'(STAGE_DLY - 1);
    localparam logic [IDX_W-1:0] IDX_LAST   = IDX_W'(NUM_STAGES - 1);

    seq_state_t            state_q, state_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic [IDX_W-1:0]      idx_q, idx_d;
    logic [NUM_STAGES-1:0] rst_n_q, rst_n_d;
    logic [NUM_STAGES-1:0] rst_q;
    logic                  done_q, done_d;
    logic                  lock_s;
    logic                  abort;

    sync_2ff u_lock_sync (
        .clk    (clk),
        .arst_n (arst_n),
        .d      (lock_in),
        .q      (lock_s)
    );

    // Lock loss only matters once domains may already be running; a
    // software request aborts from anywhere, including HOLD itself.
    assign abort = sw_rst || (!lock_s && (state_q == RELEASE || state_q == RUN));

`ifdef RESET_SEQ_WDT_EN
    localparam logic [CNT_W-1:0] WDT_LAST = CNT_W'(WDT_CYCLES - 1);
    logic wdt_q, wdt_d;
`endif

    // Next-state, counter, stage index and output decisions.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        idx_d   = idx_q;
        rst_n_d = rst_n_q;
        done_d  = done_q;
`ifdef RESET_SEQ_WDT_EN
        wdt_d   = wdt_q;
`endif
        if (abort) begin
            state_d = HOLD;
            cnt_d   = '0;
            idx_d   = '0;
            rst_n_d = '0;
            done_d  = 1'b0;
        end else begin
            case (state_q)
                HOLD: begin
                    rst_n_d = '0;
                    done_d  = 1'b0;
                    if (cnt_q == HOLD_LAST) begin
                        state_d = WAIT_LOCK;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
                WAIT_LOCK: begin
                    rst_n_d = '0;
                    done_d  = 1'b0;
                    if (lock_s) begin
                        state_d = RELEASE;
                        cnt_d   = '0;
                        idx_d   = '0;
                    end else begin
`ifdef RESET_SEQ_WDT_EN
                        if (cnt_q == WDT_LAST) begin
                            wdt_d   = 1'b1;
                            state_d = HOLD;
                            cnt_d   = '0;
                        end else begin
                            cnt_d = cnt_q + CNT_W'(1);
                        end
`else
                        cnt_d = '0;
`endif
                    end
                end
                RELEASE: begin
                    if (cnt_q == STAGE_LAST) begin
                        for (int i = 0; i < NUM_STAGES; i++) begin
                            if (idx_q == IDX_W'(i)) rst_n_d[i] = 1'b1;
                        end
                        cnt_d = '0;
                        idx_d = idx_q + IDX_W'(1);
                        if (idx_q == IDX_LAST) begin
                            state_d = RUN;
                            done_d  = 1'b1;
                        end
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
                RUN: begin
                    state_d = RUN;
                end
                default: begin
                    state_d = HOLD;
                    cnt_d   = '0;
                    idx_d   = '0;
                    rst_n_d = '0;
                    done_d  = 1'b0;
                end
            endcase
        end
    end

    // FSM state register.
    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) state_q <= HOLD;
        else         state_q <= state_d;
    end

    // Counter, stage index and registered reset outputs; rst_out is kept as
    // its own flop so neither polarity has logic after the register.
    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            cnt_q   <= '0;
            idx_q   <= '0;
            rst_n_q <= '0;
            rst_q   <= '1;
            done_q  <= 1'b0;
        end else begin
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            rst_n_q <= rst_n_d;
            rst_q   <= ~rst_n_d;
            done_q  <= done_d;
        end
    end

`ifdef RESET_SEQ_WDT_EN
    // Sticky lock-timeout flag, cleared only by arst_n.
    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) wdt_q <= 1'b0;
        else         wdt_q <= wdt_d;
    end

    assign wdt_err = wdt_q;
`else
    assign wdt_err = 1'b0;
`endif

    assign rst_n_out = rst_n_q;
    assign rst_out   = rst_q;
    assign seq_done  = done_q;

endmodule

// File: tb/tb_reset_sequencer.sv
// Directed bench for reset_sequencer with default staging parameters and
// WDT_CYCLES=32. Inputs change and outputs are sampled 1 time unit after
// the rising clock edge. Covers boot release, lock loss, software abort,
// coincident abort, asynchronous reset and the lock-wait path (watchdog
// retry when RESET_SEQ_WDT_EN is defined, indefinite wait otherwise).
module tb_reset_sequencer;

    logic       clk = 1'b0;
    logic       arst_n;
    logic       lock_in;
    logic       sw_rst;
    logic [3:0] rst_n_out;
    logic [3:0] rst_out;
    logic       seq_done;
    logic       wdt_err;

    int   vectors     = 0;
    int   miscompares = 0;
    logic exp_wdt     = 1'b0;

    reset_sequencer #(
        .NUM_STAGES (4),
        .MIN_HOLD   (8),
        .STAGE_DLY  (16),
        .WDT_CYCLES (32)
    ) dut (
        .clk       (clk),
        .arst_n    (arst_n),
        .lock_in   (lock_in),
        .sw_rst    (sw_rst),
        .rst_n_out (rst_n_out),
        .rst_out   (rst_out),
        .seq_done  (seq_done),
        .wdt_err   (wdt_err)
    );

    // 10-unit clock, rising edges at 5, 15, 25, ...
    always #5 clk = ~clk;

    // Advance n rising edges and settle just past the last one.
    task automatic waitEdges(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input logic lock, input logic sw);
        lock_in = lock;
        sw_rst  = sw;
    endtask

    task automatic checkOutput(input string tag, input logic [3:0] exp_n, input logic exp_done);
        logic [3:0] exp_p;
        exp_p = ~exp_n;
        vectors++;
        assert (rst_n_out === exp_n) else begin
            miscompares++;
            $error("[TB] FAIL %s rst_n_out observed=%b expected=%b", tag, rst_n_out, exp_n);
        end
        vectors++;
        assert (rst_out === exp_p) else begin
            miscompares++;
            $error("[TB] FAIL %s rst_out observed=%b expected=%b", tag, rst_out, exp_p);
        end
        vectors++;
        assert (seq_done === exp_done) else begin
            miscompares++;
            $error("[TB] FAIL %s seq_done observed=%b expected=%b", tag, seq_done, exp_done);
        end
        vectors++;
        assert (wdt_err === exp_wdt) else begin
            miscompares++;
            $error("[TB] FAIL %s wdt_err observed=%b expected=%b", tag, wdt_err, exp_wdt);
        end
    endtask

    // Full release check; d is the number of edges from now until the edge
    // on which WAIT_LOCK samples lock_s=1. Stage k then releases 16*(k+1)
    // edges after that one.
    task automatic checkRelease(input string tag, input int d);
        waitEdges(d + 15);
        checkOutput({tag, "_s0_pre"}, 4'b0000, 1'b0);
        waitEdges(1);
        checkOutput({tag, "_s0"}, 4'b0001, 1'b0);
        waitEdges(15);
        checkOutput({tag, "_s1_pre"}, 4'b0001, 1'b0);
        waitEdges(1);
        checkOutput({tag, "_s1"}, 4'b0011, 1'b0);
        waitEdges(15);
        checkOutput({tag, "_s2_pre"}, 4'b0011, 1'b0);
        waitEdges(1);
        checkOutput({tag, "_s2"}, 4'b0111, 1'b0);
        waitEdges(15);
        checkOutput({tag, "_s3_pre"}, 4'b0111, 1'b0);
        waitEdges(1);
        checkOutput({tag, "_s3"}, 4'b1111, 1'b1);
    endtask

    // Hard stop in case the sequence ever stalls.
    initial begin
        #100000;
        $display("[TB] FAIL timeout: simulation did not finish");
        $fatal(1, "[TB] timeout");
    end

    // Directed sequence.
    initial begin
        arst_n = 1'b0;
        applyStimulus(1'b1, 1'b0);
        #23;
        checkOutput("reset", 4'b0000, 1'b0);

        // Boot with lock already present: 8 HOLD edges, lock sampled on edge 9.
        @(posedge clk);
        #1;
        arst_n = 1'b1;
        checkRelease("boot", 9);

        // Lock loss in RUN: lock_s falls after 2 edges, abort on the 3rd.
        applyStimulus(1'b0, 1'b0);
        waitEdges(2);
        checkOutput("lockloss_hold", 4'b1111, 1'b1);
        waitEdges(1);
        checkOutput("lockloss", 4'b0000, 1'b0);
        applyStimulus(1'b1, 1'b0);
        checkRelease("relock", 9);

        // Software abort from RUN, then a second one mid-RELEASE after 0011.
        applyStimulus(1'b1, 1'b1);
        waitEdges(1);
        applyStimulus(1'b1, 1'b0);
        checkOutput("sw_run", 4'b0000, 1'b0);
        waitEdges(25);
        checkOutput("sw_mid_s0", 4'b0001, 1'b0);
        waitEdges(16);
        checkOutput("sw_mid_s1", 4'b0011, 1'b0);
        waitEdges(4);
        checkOutput("sw_mid_pre", 4'b0011, 1'b0);
        applyStimulus(1'b1, 1'b1);
        waitEdges(1);
        applyStimulus(1'b1, 1'b0);
        checkOutput("sw_mid", 4'b0000, 1'b0);
        checkRelease("sw_restart", 9);

        // sw_rst sampled on the same edge that first sees lock_s=0.
        applyStimulus(1'b0, 1'b0);
        waitEdges(2);
        checkOutput("coinc_pre", 4'b1111, 1'b1);
        applyStimulus(1'b0, 1'b1);
        waitEdges(1);
        checkOutput("coinc", 4'b0000, 1'b0);
        applyStimulus(1'b1, 1'b0);
        checkRelease("coinc_restart", 9);

        // Asynchronous reset mid-RELEASE, no clock edge in between.
        applyStimulus(1'b1, 1'b1);
        waitEdges(1);
        applyStimulus(1'b1, 1'b0);
        waitEdges(41);
        checkOutput("arst_pre", 4'b0011, 1'b0);
        #2;
        arst_n = 1'b0;
        #1;
        checkOutput("arst_async", 4'b0000, 1'b0);
        @(posedge clk);
        #1;
        arst_n = 1'b1;
        checkRelease("arst_restart", 9);

        // Lock held low from reset release.
        @(posedge clk);
        #1;
        arst_n = 1'b0;
        applyStimulus(1'b0, 1'b0);
        waitEdges(1);
        arst_n = 1'b1;
`ifdef RESET_SEQ_WDT_EN
        waitEdges(39);
        checkOutput("wdt_pre", 4'b0000, 1'b0);
        waitEdges(1);
        exp_wdt = 1'b1;
        checkOutput("wdt_trip", 4'b0000, 1'b0);
        applyStimulus(1'b1, 1'b0);
        checkRelease("wdt_retry", 9);
`else
        waitEdges(60);
        checkOutput("nolock_wait", 4'b0000, 1'b0);
        applyStimulus(1'b1, 1'b0);
        checkRelease("late_lock", 3);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/reset_sequencer.md
# reset_sequencer

Staged reset release controller sitting directly downstream of the reset bridge. Its asynchronous active-low reset input is driven by the bridge's synchronised `srst_n`. It waits for PLL lock, then releases a set of per-domain resets one at a time with a fixed spacing. Lock loss or a software request re-asserts every domain and restarts the sequence.

## Interface
- `NUM_STAGES`, 4: number of staged reset outputs, 1..16.
- `MIN_HOLD`, 8: minimum cycles all outputs stay asserted in HOLD, ≥1.
- `STAGE_DLY`, 16: cycles between consecutive stage releases, ≥1.
- `WDT_CYCLES`, 1024: lock-wait timeout in cycles, ≥2; used only with the watchdog feature.
- `clk`  in  1  single clock.
- `arst_n`  in  1  asynchronous, active-low reset, fed from the bridge's `srst_n`.
- `lock_in`  in  1  PLL lock, asynchronous to `clk`.
- `sw_rst`  in  1  synchronous one-cycle software reset request.
- `rst_n_out`  out  NUM_STAGES  per-domain active-low resets; bit 0 is released first.
- `rst_out`  out  NUM_STAGES  bitwise inverse of `rst_n_out`, also registered.
- `seq_done`  out  1  high while all stages are released.
- `wdt_err`  out  1  sticky lock-timeout flag.

## Operation
- While `arst_n`=0, immediately:
  - `rst_n_out`=0, `rst_out`=all ones.
  - `seq_done`=0, `wdt_err`=0.
  - State is HOLD, counter and stage index are 0.
- `lock_in` passes through a 2-FF synchroniser to produce `lock_s`. The synchroniser flops reset to 0.
- States:
  - **HOLD**: all outputs asserted and counter increments. When counter==MIN_HOLD-1, go to WAIT_LOCK and clear the counter.
  - **WAIT_LOCK**: outputs asserted. When `lock_s`=1, go to RELEASE with counter=0 and idx=0.
  - **RELEASE**: counter increments. When counter==STAGE_DLY-1:
    - `rst_n_out[idx]`<=1, counter<=0, idx<=idx+1.
    - If idx==NUM_STAGES-1, go to RUN and set `seq_done`<=1 on the same edge.
  - **RUN**: hold all released. No counting.
- Abort: `sw_rst`=1 in any state, or `lock_s`=0 in RELEASE or RUN:
  - Next edge: go to HOLD, set `rst_n_out`=0, clear `seq_done`, clear counter and idx.
  - HOLD then restarts its full MIN_HOLD count.
- Simultaneous `sw_rst` and lock loss cause a single abort; there is no double hold.
- `sw_rst` during HOLD restarts the HOLD count.
- Released stages are never re-asserted individually; re-assertion is always all-or-nothing.
- Counter width is clog2(max(MIN_HOLD, STAGE_DLY, WDT_CYCLES)). Idx width is clog2(NUM_STAGES)+1. Counter comparisons are unsigned and the counter never wraps.

## Timing
- All outputs are registered; there is no combinational input-to-output path.
- `lock_in` rising reaches `lock_s` after 2–3 edges.
- Release timing, counting from the edge WAIT_LOCK samples `lock_s`=1:
  - Stage k releases STAGE_DLY×(k+1) edges later.
  - `seq_done` rises with the last stage.
- Abort response: 1 edge after `sw_rst` is sampled, and 1 edge after `lock_s` falls.
- `arst_n` assertion takes effect asynchronously. Deassertion is already synchronised upstream.

## Configuration
- `RESET_SEQ_WDT_EN` defined:
  - In WAIT_LOCK the counter increments.
  - When counter==WDT_CYCLES-1 without lock: `wdt_err`<=1 (sticky until `arst_n`), go to HOLD, then retry.
- Undefined:
  - WAIT_LOCK waits indefinitely.
  - `wdt_err` is tied 0; the port remains present.

## Structure
- Package `reset_seq_pkg` holds:
  - The state enum: HOLD=0, WAIT_LOCK=1, RELEASE=2, RUN=3.
  - The counter-width clog2 helper function.
- Sub-module `sync_2ff`: 1-bit two-flop synchroniser with async active-low reset, used for `lock_in`.

## Test plan
- Default parameters, `lock_in`=1 before `arst_n` release:
  - HOLD lasts 8 cycles.
  - `rst_n_out` goes 0001, 0011, 0111, 1111 at 16-cycle spacing.
  - `seq_done` rises with 1111.
- `lock_in` drops in RUN: `rst_n_out`=0000 and `seq_done`=0 within 3 edges. On re-lock the full sequence repeats.
- `sw_rst` pulse mid-RELEASE (after 0011): next edge gives 0000. Then 8 HOLD cycles, then restart from stage 0.
- `sw_rst` coincident with lock loss: exactly one HOLD of 8 cycles.
- `arst_n` asserted mid-RELEASE: outputs go 0000 with no clock edge required.
- With `RESET_SEQ_WDT_EN` defined and WDT_CYCLES=32, `lock_in` held 0:
  - `wdt_err` rises 32 cycles into WAIT_LOCK and stays 1 after a later lock.
  - The sequence then completes.
  - Without the macro, `wdt_err` stays 0.
